// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer and the ALU datapath:
// opcode encodings, sequencer state encoding and response flag bit positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_ILLEGAL = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_AND     = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_EQ      = 3'b101;
    localparam logic [2:0] OP_LT      = 3'b110;
    localparam logic [2:0] OP_GT      = 3'b111;

    localparam int FLG_CARRY = 4;
    localparam int FLG_ZERO  = 3;
    localparam int FLG_EQ    = 2;
    localparam int FLG_LT    = 1;
    localparam int FLG_GT    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

    // Only the value-producing operations update the accumulator; compares do not.
    function automatic logic op_writes_acc(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [4:0] pack_flags(input logic carry, input logic zero,
                                              input logic eq, input logic lt,
                                              input logic gt);
        logic [4:0] f;
        f            = '0;
        f[FLG_CARRY] = carry;
        f[FLG_ZERO]  = zero;
        f[FLG_EQ]    = eq;
        f[FLG_LT]    = lt;
        f[FLG_GT]    = gt;
        return f;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the 3-bit ALU: takes one request at a time, issues it
// to the external ALU for one cycle, and returns the captured result and flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    input  logic       cmd_chain,
    output logic [2:0] alu_sel,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [2:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_equal,
    input  logic       alu_lt,
    input  logic       alu_gt,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_result,
    output logic [4:0] rsp_flags,
    output logic       rsp_err,
    output logic [2:0] acc
);

    seq_state_e state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [2:0] result_q, result_d;
    logic [4:0] flags_q, flags_d;
    logic       err_q, err_d;
    logic [2:0] acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ILLEGAL;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        acc_d    = acc_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_chain ? acc_q : cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op == OP_ILLEGAL) begin
                        // Illegal requests bypass the ALU and answer with a cleared payload.
                        result_d = '0;
                        flags_d  = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                result_d = alu_result;
                flags_d  = pack_flags(alu_carry, alu_zero, alu_equal, alu_lt, alu_gt);
                err_d    = 1'b0;
                if (op_writes_acc(op_q)) begin
                    acc_d = alu_result;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The ALU sees a live select only during the single issue cycle.
    assign alu_sel    = (state_q == ISSUE) ? op_q : OP_ILLEGAL;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign acc        = acc_q;

    property p_rsp_hold;
        @(posedge clk) disable iff (!rst_n)
            (rsp_valid && !rsp_ready) |=>
                (rsp_valid && $stable(rsp_result) && $stable(rsp_flags) && $stable(rsp_err));
    endproperty
    a_rsp_hold: assert property (p_rsp_hold);

    a_sel_quiet: assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q != ISSUE) |-> (alu_sel == OP_ILLEGAL));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a reference ALU beside the DUT, a transaction-level
// model checked every cycle, and directed commands with literal expectations.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic       cmd_chain;
    logic [2:0] alu_sel;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [2:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_equal;
    logic       alu_lt;
    logic       alu_gt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_result;
    logic [4:0] rsp_flags;
    logic       rsp_err;
    logic [2:0] acc;

    int n_checks = 0;
    int n_pass   = 0;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_equal  (alu_equal),
        .alu_lt     (alu_lt),
        .alu_gt     (alu_gt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .acc        (acc)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {result[2:0], carry, zero, equal, lt, gt}.
    function automatic logic [7:0] alu_ref(input logic [2:0] sel, input logic [2:0] a,
                                           input logic [2:0] b);
        int s;
        logic [2:0] r;
        logic c, z, e, l, g;
        r = 3'd0; c = 1'b0; z = 1'b0; e = 1'b0; l = 1'b0; g = 1'b0;
        case (sel)
            OP_ADD: begin s = int'(a) + int'(b); r = 3'(s % 8); c = (s > 7); z = (r == 3'd0); end
            OP_SUB: begin s = int'(a) - int'(b); r = 3'((s + 8) % 8); c = (a < b); z = (r == 3'd0); end
            OP_AND: begin r = a & b; z = (r == 3'd0); end
            OP_OR:  begin r = a | b; z = (r == 3'd0); end
            OP_EQ:  begin e = (a == b); r = {2'b00, e}; end
            OP_LT:  begin l = (a < b);  r = {2'b00, l}; end
            OP_GT:  begin g = (a > b);  r = {2'b00, g}; end
            default: begin r = 3'd0; end
        endcase
        return {r, c, z, e, l, g};
    endfunction

    always_comb begin
        {alu_result, alu_carry, alu_zero, alu_equal, alu_lt, alu_gt} = alu_ref(alu_sel, alu_a, alu_b);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Transaction model: m_since counts edges since the accept edge.
    bit         m_busy = 1'b0;
    int         m_since = 0;
    int         m_lat = 0;
    logic [2:0] m_op = 3'd0, m_a = 3'd0, m_b = 3'd0, m_res = 3'd0, m_acc = 3'd0;
    logic [4:0] m_flg = 5'd0;
    bit         m_err = 1'b0;

    always @(negedge clk) begin
        bit exp_valid, exp_issue;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_acc  = 3'd0;
            chk("m.rst.cmd_ready", int'(cmd_ready), 1);
            chk("m.rst.rsp_valid", int'(rsp_valid), 0);
            chk("m.rst.alu_sel", int'(alu_sel), 0);
            chk("m.rst.alu_ab", int'({alu_a, alu_b}), 0);
            chk("m.rst.rsp", int'({rsp_result, rsp_flags, rsp_err}), 0);
            chk("m.rst.acc", int'(acc), 0);
        end else begin
            exp_valid = m_busy && (m_since >= m_lat);
            exp_issue = m_busy && !m_err && (m_since == 1);
            chk("m.cmd_ready", int'(cmd_ready), int'(!m_busy));
            chk("m.rsp_valid", int'(rsp_valid), int'(exp_valid));
            chk("m.alu_sel", int'(alu_sel), exp_issue ? int'(m_op) : 0);
            chk("m.acc", int'(acc), int'(m_acc));
            if (exp_issue) begin
                chk("m.alu_a", int'(alu_a), int'(m_a));
                chk("m.alu_b", int'(alu_b), int'(m_b));
            end
            if (exp_valid) begin
                chk("m.rsp_result", int'(rsp_result), int'(m_res));
                chk("m.rsp_flags", int'(rsp_flags), int'(m_flg));
                chk("m.rsp_err", int'(rsp_err), int'(m_err));
            end
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy  = 1'b1;
                    m_since = 1;
                    m_op    = cmd_op;
                    m_a     = cmd_chain ? m_acc : cmd_a;
                    m_b     = cmd_b;
                    if (cmd_op == OP_ILLEGAL) begin
                        m_err = 1'b1; m_res = 3'd0; m_flg = 5'd0; m_lat = 1;
                    end else begin
                        m_err = 1'b0; {m_res, m_flg} = alu_ref(m_op, m_a, m_b); m_lat = 2;
                    end
                end
            end else if (exp_valid) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                m_since++;
                if (m_since == 2 && (m_op == OP_ADD || m_op == OP_SUB ||
                                     m_op == OP_AND || m_op == OP_OR))
                    m_acc = m_res;
            end
        end
    end

    // Starts just after a rising edge with the DUT idle and rsp_ready=1.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [2:0] a,
                           input logic [2:0] b, input logic chain, input int exp_a,
                           input int exp_res, input int exp_flg, input int exp_err,
                           input int exp_acc, input int exp_lat);
        int w;
        int lat;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk({name, ".accept_timeout"}, 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (lat = 1; lat <= 8; lat++) begin
            @(negedge clk);
            if (exp_err != 0) chk({name, ".sel_quiet"}, int'(alu_sel), 0);
            if (rsp_valid) break;
            if (lat == 1) begin
                chk({name, ".issue_sel"}, int'(alu_sel), int'(op));
                chk({name, ".issue_a"}, int'(alu_a), exp_a);
                chk({name, ".issue_b"}, int'(alu_b), int'(b));
            end
            @(posedge clk);
        end
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".result"}, int'(rsp_result), exp_res);
        chk({name, ".flags"}, int'(rsp_flags), exp_flg);
        chk({name, ".err"}, int'(rsp_err), exp_err);
        chk({name, ".acc"}, int'(acc), exp_acc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 3'd0; cmd_b = 3'd0;
        cmd_chain = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cmd_ready", int'(cmd_ready), 1);
        chk("reset.rsp_valid", int'(rsp_valid), 0);
        chk("reset.acc", int'(acc), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd("add54",  OP_ADD, 3'd5, 3'd4, 1'b0, 5, 1, 5'b10000, 0, 1, 2);
        run_cmd("sub23",  OP_SUB, 3'd2, 3'd3, 1'b0, 2, 7, 5'b10000, 0, 7, 2);
        run_cmd("sub33",  OP_SUB, 3'd3, 3'd3, 1'b0, 3, 0, 5'b01000, 0, 0, 2);
        run_cmd("add32",  OP_ADD, 3'd3, 3'd2, 1'b0, 3, 5, 5'b00000, 0, 5, 2);
        run_cmd("andch",  OP_AND, 3'd1, 3'd6, 1'b1, 5, 4, 5'b00000, 0, 4, 2);
        run_cmd("ltch",   OP_LT,  3'd2, 3'd7, 1'b1, 4, 1, 5'b00010, 0, 4, 2);
        run_cmd("illeg",  OP_ILLEGAL, 3'd7, 3'd7, 1'b0, 7, 0, 5'b00000, 1, 4, 1);
        run_cmd("eq33",   OP_EQ,  3'd3, 3'd3, 1'b0, 3, 1, 5'b00100, 0, 4, 2);
        run_cmd("gt62",   OP_GT,  3'd6, 3'd2, 1'b0, 6, 1, 5'b00001, 0, 4, 2);

        // Backpressure with a second command waiting on the host side.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 3'd1; cmd_b = 3'd1; cmd_chain = 1'b0;
        @(negedge clk);
        chk("bp.ready_idle", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_op = OP_OR; cmd_a = 3'd1; cmd_b = 3'd2;
        @(negedge clk);
        chk("bp.issue_sel", int'(alu_sel), int'(OP_ADD));
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", int'(rsp_valid), 1);
            chk("bp.hold_result", int'(rsp_result), 2);
            chk("bp.hold_flags", int'(rsp_flags), 0);
            chk("bp.hold_ready", int'(cmd_ready), 0);
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.last_valid", int'(rsp_valid), 1);
        chk("bp.last_ready", int'(cmd_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.after_hs_ready", int'(cmd_ready), 1);
        chk("bp.after_hs_valid", int'(rsp_valid), 0);
        chk("bp.after_hs_sel", int'(alu_sel), 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp.pend_sel", int'(alu_sel), int'(OP_OR));
        chk("bp.pend_a", int'(alu_a), 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp.pend_valid", int'(rsp_valid), 1);
        chk("bp.pend_result", int'(rsp_result), 3);
        chk("bp.pend_acc", int'(acc), 3);
        @(posedge clk);
        #1;

        // Reset in the middle of an issue cycle.
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 3'd7; cmd_b = 3'd7; cmd_chain = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.cmd_ready", int'(cmd_ready), 1);
        chk("rstmid.alu_sel", int'(alu_sel), 0);
        chk("rstmid.alu_a", int'(alu_a), 0);
        chk("rstmid.rsp_valid", int'(rsp_valid), 0);
        chk("rstmid.acc", int'(acc), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid.no_rsp", int'(rsp_valid), 0);
            chk("rstmid.acc_zero", int'(acc), 0);
        end
        @(posedge clk);
        #1;

        run_cmd("chain_after_rst", OP_ADD, 3'd7, 3'd2, 1'b1, 0, 2, 5'b00000, 0, 2, 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

endmodule
